// File: rtl/rv_alu_exec_if.sv
// Handshake/data bundle for the execute-stage ALU.
// slave is the ALU's view. master is the view of the surrounding
// pipeline, which drives operations upstream and consumes results downstream.
interface rv_alu_exec_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  // upstream side
  logic               in_valid_i;
  logic               in_ready_o;
  logic [3:0]         alu_op_sel_i;
  logic [XLEN-1:0]    op_a_i;
  logic [XLEN-1:0]    op_b_i;
  logic [RADDR_W-1:0] rd_addr_i;
  logic               flush_i;
  // downstream side
  logic               out_valid_o;
  logic               out_ready_i;
  logic [XLEN-1:0]    result_o;
  logic               zero_o;
  logic               illegal_o;
  logic [RADDR_W-1:0] rd_addr_o;

  modport slave (
    input  in_valid_i, alu_op_sel_i, op_a_i, op_b_i, rd_addr_i, flush_i,
           out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, illegal_o, rd_addr_o
  );

  modport master (
    output in_valid_i, alu_op_sel_i, op_a_i, op_b_i, rd_addr_i, flush_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, illegal_o, rd_addr_o
  );
endinterface

// File: rtl/rv_alu_exec.sv
// Execute-stage ALU with a single-entry output register and valid/ready
// backpressure on both sides. Flush squashes the held entry and blocks intake.
module rv_alu_exec #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  rv_alu_exec_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Everything the stage holds besides the valid state.
  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic               zero;
    logic               illegal;
    logic [RADDR_W-1:0] rd_addr;
  } rsp_t;

  state_t state_q;
  rsp_t   rsp_q;
  rsp_t   rsp_d;
  logic   accept;

  // Combinational ALU: illegal codes produce 0 and are never flagged zero.
  always_comb begin
    rsp_d         = '0;
    rsp_d.rd_addr = bus.rd_addr_i;
    unique case (bus.alu_op_sel_i)
      OP_ADD:  rsp_d.result = bus.op_a_i + bus.op_b_i;
      OP_SUB:  rsp_d.result = bus.op_a_i - bus.op_b_i;
      OP_AND:  rsp_d.result = bus.op_a_i & bus.op_b_i;
      OP_OR:   rsp_d.result = bus.op_a_i | bus.op_b_i;
      default: rsp_d.illegal = 1'b1;
    endcase
    rsp_d.zero = !rsp_d.illegal && (rsp_d.result == '0);
  end

  // Ready is combinational so a draining entry can be replaced in one cycle.
  assign bus.in_ready_o = !bus.flush_i && ((state_q == EMPTY) || bus.out_ready_i);
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  // Stage state and output register. Flush wins over accept and drain, and it
  // leaves the payload untouched because it is don't-care once invalid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      rsp_q   <= '0;
    end else if (bus.flush_i) begin
      state_q <= EMPTY;
    end else if (accept) begin
      state_q <= FULL;
      rsp_q   <= rsp_d;
    end else if (bus.out_ready_i) begin
      state_q <= EMPTY;
    end
  end

  assign bus.out_valid_o = (state_q == FULL);
  assign bus.result_o    = rsp_q.result;
  assign bus.zero_o      = rsp_q.zero;
  assign bus.illegal_o   = rsp_q.illegal;
  assign bus.rd_addr_o   = rsp_q.rd_addr;

endmodule
